// File: rtl/fft_params_pkg.sv
// Shared parameters, types and address arithmetic for the fft256 stage sequencer.
// Imported by the stage AGU, its interface and the write-back delay line.
package fft_params_pkg;

    localparam int N        = 256;
    localparam int LOG2N    = $clog2(N);
    localparam int STAGES   = LOG2N;
    localparam int RD_LAT   = 1;
    localparam int BF_LAT   = 4;
    localparam int PIPE_LAT = RD_LAT + BF_LAT;

    typedef logic [LOG2N-1:0]         addr_t;
    typedef logic [LOG2N-2:0]         tw_addr_t;
    typedef logic [LOG2N-2:0]         k_t;
    typedef logic [$clog2(LOG2N)-1:0] stage_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} agu_state_t;

    typedef struct packed {
        logic  valid;
        addr_t a;
        addr_t b;
    } wb_entry_t;

    typedef struct packed {
        addr_t    a;
        addr_t    b;
        tw_addr_t tw;
    } bf_addr_t;

    function automatic stage_t clamp_stage(input stage_t idx);
        if (32'(idx) >= LOG2N) return stage_t'(LOG2N - 1);
        return idx;
    endfunction

    // Butterfly k of stage s: insert a zero bit at position s for leg a, set it for leg b.
    function automatic bf_addr_t bf_addr(input k_t k, input stage_t s);
        int unsigned sh;
        addr_t       kk, half, pos;
        bf_addr_t    r;
        sh   = 32'(s);
        kk   = addr_t'(k);
        half = addr_t'(1) << sh;
        pos  = kk & (half - addr_t'(1));
        r.a  = ((kk >> sh) << (sh + 1)) | pos;
        r.b  = r.a + half;
        r.tw = tw_addr_t'(pos << (LOG2N - 1 - sh));
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_agu_if.sv
// Control/memory-side signal bundle of the stage AGU.
// master = control FSM and memory side, slave = the AGU itself.
interface fft_stage_agu_if;
    import fft_params_pkg::*;

    logic     stage_start;
    stage_t   stage_idx;
    logic     mem_ready;
    logic     rd_en;
    addr_t    rd_addr_a;
    addr_t    rd_addr_b;
    tw_addr_t tw_addr;
    logic     wr_en;
    addr_t    wr_addr_a;
    addr_t    wr_addr_b;
    logic     busy;
    logic     stage_done;

    modport master (
        output stage_start, stage_idx, mem_ready,
        input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  wr_en, wr_addr_a, wr_addr_b, busy, stage_done
    );

    modport slave (
        input  stage_start, stage_idx, mem_ready,
        output rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output wr_en, wr_addr_a, wr_addr_b, busy, stage_done
    );

endinterface

// File: rtl/fft_addr_delay_line.sv
// Fixed-depth {valid,a,b} shift register that replays read pairs as write-back pairs.
// empty_next reports whether the line will hold no valid entry after the coming edge.
module fft_addr_delay_line
    import fft_params_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT
) (
    input  logic      clk,
    input  logic      rst,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      empty_next
);

    wb_entry_t pipe [DEPTH];
    wb_entry_t nxt  [DEPTH];

    // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        nxt[0]     = din;
        empty_next = !din.valid;
        for (int i = 1; i < DEPTH; i++) begin
            nxt[i] = pipe[i-1];
            if (pipe[i-1].valid) empty_next = 1'b0;
        end
    end

    // NOTE: the whole line is reset, not just the valid bits, because its tail drives wr_addr_* directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= nxt[i];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_agu.sv
// Per-stage butterfly address sequencer for the fft256 radix-2 DIT datapath.
// Issues N/2 read pairs with twiddle addresses, replays them as writes after PIPE_LAT, pulses stage_done.
module fft_stage_agu
    import fft_params_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fft_stage_agu_if.slave bus
);

    localparam k_t K_LAST = k_t'(N/2 - 1);

    agu_state_t state;
    k_t         k;
    stage_t     s_q;

    logic       accept;
    logic       issue;
    k_t         cur_k;
    stage_t     cur_s;
    bf_addr_t   addr;
    wb_entry_t  wb_in;
    wb_entry_t  wb_out;
    logic       line_empty_next;

    // The accepting edge already issues k=0, so rd_en rises the cycle after stage_start.
    always_comb begin
        accept = bus.stage_start && (state == IDLE);
        cur_s  = accept ? clamp_stage(bus.stage_idx) : s_q;
        cur_k  = accept ? '0 : k;
        issue  = bus.mem_ready && (accept || (state == ISSUE));
        addr   = bf_addr(cur_k, cur_s);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            k              <= '0;
            s_q            <= '0;
            bus.rd_en      <= 1'b0;
            bus.rd_addr_a  <= '0;
            bus.rd_addr_b  <= '0;
            bus.tw_addr    <= '0;
            bus.busy       <= 1'b0;
            bus.stage_done <= 1'b0;
        end else begin
            bus.rd_en      <= issue;
            bus.stage_done <= 1'b0;
            bus.busy       <= accept || (state != IDLE);

            if (accept) begin
                s_q   <= cur_s;
                k     <= '0;
                state <= ISSUE;
            end

            if (issue) begin
                bus.rd_addr_a <= addr.a;
                bus.rd_addr_b <= addr.b;
                bus.tw_addr   <= addr.tw;
                k             <= cur_k + 1'b1;
                if (cur_k == K_LAST) state <= DRAIN;
            end

            // Finish once the coming edge empties the line: stage_done lands right after the last wr_en.
            if ((state == DRAIN) && line_empty_next) begin
                state          <= IDLE;
                bus.stage_done <= 1'b1;
            end
        end
    end

    assign wb_in = '{valid: bus.rd_en, a: bus.rd_addr_a, b: bus.rd_addr_b};

    fft_addr_delay_line #(
        .DEPTH(PIPE_LAT)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .din       (wb_in),
        .dout      (wb_out),
        .empty_next(line_empty_next)
    );

    assign bus.wr_en     = wb_out.valid;
    assign bus.wr_addr_a = wb_out.a;
    assign bus.wr_addr_b = wb_out.b;

endmodule

// File: tb/tb_fft_stage_agu.sv
// Directed bench for fft_stage_agu: no-stall stages, stall gap, ignored start,
// back-to-back stages and mid-stage reset, checked against hand-derived timing.
module tb_fft_stage_agu;
    import fft_params_pkg::*;

    logic clk = 1'b0;
    logic rst;

    fft_stage_agu_if bus();

    fft_stage_agu dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int rd_err, wr_err, tw_err, busy_err, cover_err;
    int done_cnt, done_cyc;
    int rd_first, rd_last, wr_first, wr_last;
    int k9_a, k9_b, k9_tw;

    // Expected pair written as "upper part of k times a block, plus offset in the block".
    task automatic exp_addr(input int k, input int s, output int a, output int b, output int tw);
        int half, lower, upper;
        half  = 1 << s;
        lower = k % half;
        upper = k / half;
        a     = upper * 2 * half + lower;
        b     = a + half;
        tw    = lower * ((N / 2) / half);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse stage_start in "cycle 0"; returns #1 into cycle 1.
    task automatic accept_stage(input int s);
        bus.stage_idx   = stage_t'(s);
        bus.stage_start = 1'b1;
        bus.mem_ready   = 1'b1;
        step();
        bus.stage_start = 1'b0;
    endtask

    // Observe one stage from cycle 1 on, comparing each cycle with a bench model.
    task automatic observe(input int s, input int stall_at, input int stall_len,
                           input int poke_at, input int b2b_next);
        int   k_m, c, exp_done, ea, eb, et;
        logic exp_rd, exp_wr, exp_busy, prev_mem, stop;
        logic hv [0:511];
        int   ha [0:511];
        int   hb [0:511];
        int   seen [0:255];
        k_m = 0; c = 1; exp_done = -1; prev_mem = 1'b1; stop = 1'b0;
        rd_err = 0; wr_err = 0; tw_err = 0; busy_err = 0; cover_err = 0;
        done_cnt = 0; done_cyc = -1;
        rd_first = -1; rd_last = -1; wr_first = -1; wr_last = -1;
        k9_a = -1; k9_b = -1; k9_tw = -1;
        for (int i = 0; i < 512; i++) begin hv[i] = 1'b0; ha[i] = 0; hb[i] = 0; end
        for (int i = 0; i < 256; i++) seen[i] = 0;

        while (!stop && c < 400) begin
            exp_rd = prev_mem && (k_m < N/2);
            hv[c]  = exp_rd;
            if (bus.rd_en !== exp_rd) rd_err++;
            if (bus.rd_en === 1'b1) begin
                if (rd_first < 0) rd_first = c;
                rd_last = c;
            end
            if (exp_rd) begin
                exp_addr(k_m, s, ea, eb, et);
                ha[c] = ea;
                hb[c] = eb;
                if (bus.rd_addr_a !== addr_t'(ea) || bus.rd_addr_b !== addr_t'(eb)) rd_err++;
                if (bus.tw_addr !== tw_addr_t'(et)) tw_err++;
                seen[int'(bus.rd_addr_a)]++;
                seen[int'(bus.rd_addr_b)]++;
                if (k_m == 9) begin
                    k9_a = int'(bus.rd_addr_a); k9_b = int'(bus.rd_addr_b); k9_tw = int'(bus.tw_addr);
                end
                k_m++;
                if (k_m == N/2) exp_done = c + PIPE_LAT + 1;
            end

            exp_wr = (c > PIPE_LAT) ? hv[c-PIPE_LAT] : 1'b0;
            if (bus.wr_en !== exp_wr) wr_err++;
            if (bus.wr_en === 1'b1) begin
                if (wr_first < 0) wr_first = c;
                wr_last = c;
            end
            if (exp_wr && (bus.wr_addr_a !== addr_t'(ha[c-PIPE_LAT]) ||
                           bus.wr_addr_b !== addr_t'(hb[c-PIPE_LAT]))) wr_err++;

            exp_busy = (exp_done < 0) || (c <= exp_done);
            if (bus.busy !== exp_busy) busy_err++;
            if (bus.stage_done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end

            if (exp_done >= 0 && c == exp_done && b2b_next >= 0) begin
                accept_stage(b2b_next);
                stop = 1'b1;
            end else if (exp_done >= 0 && c >= exp_done + 4) begin
                stop = 1'b1;
            end else begin
                bus.mem_ready   = !(c >= stall_at && c < stall_at + stall_len);
                prev_mem        = bus.mem_ready;
                bus.stage_start = (c == poke_at);
                if (c == poke_at) bus.stage_idx = stage_t'(5);
                step();
                c++;
            end
        end
        bus.stage_start = 1'b0;
        bus.mem_ready   = 1'b1;
        for (int i = 0; i < 256; i++) if (seen[i] != 1) cover_err++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stage_start = 1'b0;
        bus.stage_idx   = '0;
        bus.mem_ready   = 1'b1;
        repeat (3) step();
        total++; if (bus.rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", bus.rd_en); else passed++;
        total++; if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); else passed++;
        total++; if (bus.busy !== 1'b0 || bus.stage_done !== 1'b0)
            $display("FAIL reset_busy_done: got busy=%b done=%b expected 0/0", bus.busy, bus.stage_done); else passed++;
        total++; if (bus.rd_addr_a !== 8'd0 || bus.wr_addr_b !== 8'd0 || bus.tw_addr !== 7'd0)
            $display("FAIL reset_addrs: got rd_a=%0d wr_b=%0d tw=%0d expected 0", bus.rd_addr_a, bus.wr_addr_b, bus.tw_addr);
        else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_stage0();
        accept_stage(0);
        observe(0, -1, 0, -1, -1);
        total++; if (rd_err != 0) $display("FAIL s0_rd_pairs: got %0d errors expected 0", rd_err); else passed++;
        total++; if (tw_err != 0) $display("FAIL s0_tw_zero: got %0d errors expected 0", tw_err); else passed++;
        total++; if (wr_err != 0) $display("FAIL s0_wr_replay: got %0d errors expected 0", wr_err); else passed++;
        total++; if (rd_first != 1 || rd_last != 128)
            $display("FAIL s0_rd_window: got %0d..%0d expected 1..128", rd_first, rd_last); else passed++;
        total++; if (wr_first != 6 || wr_last != 133)
            $display("FAIL s0_wr_window: got %0d..%0d expected 6..133", wr_first, wr_last); else passed++;
        total++; if (done_cnt != 1 || done_cyc != 134)
            $display("FAIL s0_done: got %0d pulses at %0d expected 1 at 134", done_cnt, done_cyc); else passed++;
        total++; if (busy_err != 0) $display("FAIL s0_busy: got %0d errors expected 0", busy_err); else passed++;
    endtask

    task automatic test_stage7();
        accept_stage(7);
        observe(7, -1, 0, -1, -1);
        total++; if (rd_err != 0) $display("FAIL s7_rd_pairs: got %0d errors expected 0", rd_err); else passed++;
        total++; if (tw_err != 0) $display("FAIL s7_tw_ramp: got %0d errors expected 0", tw_err); else passed++;
        total++; if (wr_err != 0 || done_cyc != 134)
            $display("FAIL s7_wr_done: got %0d errors, done at %0d expected 0, 134", wr_err, done_cyc); else passed++;
    endtask

    task automatic test_stage3();
        accept_stage(3);
        observe(3, -1, 0, -1, -1);
        total++; if (k9_a != 17 || k9_b != 25 || k9_tw != 16)
            $display("FAIL s3_k9: got a=%0d b=%0d tw=%0d expected 17 25 16", k9_a, k9_b, k9_tw); else passed++;
        total++; if (cover_err != 0) $display("FAIL s3_coverage: got %0d bad addresses expected 0", cover_err); else passed++;
        total++; if (rd_err != 0 || tw_err != 0)
            $display("FAIL s3_stream: got rd=%0d tw=%0d errors expected 0", rd_err, tw_err); else passed++;
    endtask

    task automatic test_stall();
        accept_stage(2);
        observe(2, 50, 10, -1, -1);
        total++; if (rd_err != 0) $display("FAIL stall_rd_gap: got %0d errors expected 0", rd_err); else passed++;
        total++; if (wr_err != 0) $display("FAIL stall_wr_gap: got %0d errors expected 0", wr_err); else passed++;
        total++; if (rd_last != 138 || wr_last != 143)
            $display("FAIL stall_last: got rd %0d wr %0d expected 138 143", rd_last, wr_last); else passed++;
        total++; if (done_cnt != 1 || done_cyc != 144)
            $display("FAIL stall_done: got %0d pulses at %0d expected 1 at 144", done_cnt, done_cyc); else passed++;
        total++; if (cover_err != 0) $display("FAIL stall_coverage: got %0d bad addresses expected 0", cover_err); else passed++;
    endtask

    task automatic test_ignore_start();
        accept_stage(4);
        observe(4, -1, 0, 60, -1);
        total++; if (rd_err != 0 || wr_err != 0)
            $display("FAIL ignore_stream: got rd=%0d wr=%0d errors expected 0", rd_err, wr_err); else passed++;
        total++; if (done_cnt != 1 || done_cyc != 134)
            $display("FAIL ignore_done: got %0d pulses at %0d expected 1 at 134", done_cnt, done_cyc); else passed++;
    endtask

    task automatic test_back_to_back();
        accept_stage(1);
        observe(1, -1, 0, -1, 2);
        total++; if (done_cyc != 134 || rd_err != 0)
            $display("FAIL b2b_first: got done %0d, %0d errors expected 134, 0", done_cyc, rd_err); else passed++;
        observe(2, -1, 0, -1, -1);
        total++; if (rd_first != 1) $display("FAIL b2b_second_start: got %0d expected 1", rd_first); else passed++;
        total++; if (rd_err != 0 || wr_err != 0 || done_cyc != 134)
            $display("FAIL b2b_second: got rd=%0d wr=%0d done %0d expected 0 0 134", rd_err, wr_err, done_cyc);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int active;
        accept_stage(5);
        repeat (39) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.stage_done !== 1'b0)
            $display("FAIL midrst_clear: got rd=%b wr=%b busy=%b done=%b expected 0000",
                     bus.rd_en, bus.wr_en, bus.busy, bus.stage_done);
        else passed++;
        active = 0;
        repeat (20) begin
            step();
            if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.stage_done !== 1'b0) active++;
        end
        total++; if (active != 0) $display("FAIL midrst_quiet: got %0d active cycles expected 0", active); else passed++;
    endtask

    initial begin
        test_reset();
        test_stage0();
        test_stage7();
        test_stage3();
        test_stall();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
